// File: rtl/led_flow_pkg.sv
// Shared mode encoding and width helper for the multi-mode LED sequencer.
package led_flow_pkg;

   typedef enum logic [1:0] {
      MODE_ROL  = 2'd0,
      MODE_ROR  = 2'd1,
      MODE_PING = 2'd2,
      MODE_FILL = 2'd3
   } mode_e;

   // Pos must hold 0..N_LED because fill mode counts up to N_LED lit LEDs.
   function automatic int pos_w(input int n_led);
      return $clog2(n_led + 1);
   endfunction

endpackage

// File: rtl/led_step_timer.sv
// Prescaler: emits a one-cycle tick every (BASE_DIV >> Speed) enabled cycles.
module led_step_timer #(
   parameter int unsigned BASE_DIV = 13_500_000,
   parameter int unsigned CNT_W    = 24
) (
   input  logic       Clock,
   input  logic       Reset,
   input  logic       En,
   input  logic [1:0] Speed,
   input  logic       clr,
   output logic       tick
);

   localparam logic [CNT_W-1:0] BASE = CNT_W'(BASE_DIV);

   logic [CNT_W-1:0] cnt_q, cnt_d, limit_m1;

   // >= rather than == so a mid-count speed-up wraps immediately instead of overrunning.
   always_comb begin
      limit_m1 = (BASE >> Speed) - CNT_W'(1);
      cnt_d    = cnt_q;
      tick     = 1'b0;
      if (clr) begin
         cnt_d = '0;
      end else if (En) begin
         if (cnt_q >= limit_m1) begin
            cnt_d = '0;
            tick  = 1'b1;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge Clock) begin
      if (Reset) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

endmodule

// File: rtl/led_flow_multi.sv
// Multi-mode LED sequencer: rotate-left/right, ping-pong and bar-fill patterns.
module led_flow_multi
   import led_flow_pkg::*;
#(
   parameter int unsigned N_LED    = 6,
   parameter int unsigned BASE_DIV = 13_500_000,
   parameter int unsigned CNT_W    = 24
) (
   input  logic                        Clock,
   input  logic                        Reset,
   input  logic                        En,
   input  logic [1:0]                  Mode,
   input  logic [1:0]                  Speed,
   output logic [N_LED-1:0]            LED,
   output logic                        Step,
   output logic [pos_w(N_LED)-1:0]     Pos
);

   localparam int PW = pos_w(N_LED);
   localparam logic [PW-1:0] LAST = PW'(N_LED - 1);
   localparam logic [PW-1:0] FULL = PW'(N_LED);
   localparam logic [PW-1:0] ONE  = PW'(1);

   mode_e            mode_in, mode_q;
   logic             restart, tick;
   logic [PW-1:0]    pos_q, pos_d, pos_init;
   logic             dir_q, dir_d;
   logic             step_q, step_d;
   logic [N_LED-1:0] led_q, led_d;
   logic [N_LED:0]   fill_mask;

   assign mode_in  = mode_e'(Mode);
   assign restart  = (mode_in != mode_q);
   assign pos_init = (mode_in == MODE_FILL) ? ONE : '0;

   led_step_timer #(
      .BASE_DIV (BASE_DIV),
      .CNT_W    (CNT_W)
   ) u_timer (
      .Clock (Clock),
      .Reset (Reset),
      .En    (En),
      .Speed (Speed),
      .clr   (restart),
      .tick  (tick)
   );

   always_comb begin
      pos_d  = pos_q;
      dir_d  = dir_q;
      step_d = 1'b0;
      if (restart) begin
         pos_d = pos_init;
         dir_d = 1'b1;
      end else if (tick) begin
         step_d = 1'b1;
         unique case (mode_in)
            MODE_ROL:  pos_d = (pos_q >= LAST) ? '0 : pos_q + ONE;
            MODE_ROR:  pos_d = (pos_q == '0) ? LAST : pos_q - ONE;
            MODE_PING: begin
               // Flip on the step that lands on an end so end LEDs show only once.
               if (dir_q) begin
                  pos_d = pos_q + ONE;
                  if (pos_q + ONE >= LAST) dir_d = 1'b0;
               end else begin
                  pos_d = pos_q - ONE;
                  if (pos_q <= ONE) dir_d = 1'b1;
               end
            end
            MODE_FILL: pos_d = (pos_q >= FULL) ? '0 : pos_q + ONE;
            default:   pos_d = pos_q;
         endcase
      end

      // Mask built one bit wider so k = N_LED yields all ones after truncation.
      fill_mask = ((N_LED+1)'(1) << pos_d) - (N_LED+1)'(1);
      if (mode_in == MODE_FILL) led_d = fill_mask[N_LED-1:0];
      else                      led_d = N_LED'(1) << pos_d;
   end

   always_ff @(posedge Clock) begin
      mode_q <= mode_in;
      if (Reset) begin
         pos_q  <= pos_init;
         dir_q  <= 1'b1;
         step_q <= 1'b0;
         led_q  <= N_LED'(1);
      end else begin
         pos_q  <= pos_d;
         dir_q  <= dir_d;
         step_q <= step_d;
         led_q  <= led_d;
      end
   end

   assign LED  = led_q;
   assign Step = step_q;
   assign Pos  = pos_q;

endmodule
